// File: rtl/darkroom_spi_frame_receiver.sv
// darkroom_spi_frame_receiver
//   SPI mode-0 slave for the lighthouse sensor link. Deserialises byte frames,
//   accepts only frames of exactly FRAME_BYTES bytes, buffers one good frame and
//   streams it out as 32-bit words over a valid/ready handshake.
// Ports
//   clock, reset_n                system clock, async active-low reset
//   sck_i, ss_n_i, mosi_i         asynchronous SPI inputs (MSB first)
//   word_o, word_index_o          current output word and its index in the frame
//   word_valid_o, word_ready_i    output handshake
//   frame_done_o                  pulse: last word of a frame accepted
//   frame_error_o                 pulse: received frame had a bad length
//   overflow_o                    pulse: good frame dropped, output buffer busy
//   frame_count_o                 good frames loaded into the buffer (wraps)
module darkroom_spi_frame_receiver #(
  parameter int unsigned FRAME_BYTES = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  localparam int unsigned WORDS      = FRAME_BYTES / 4,
  localparam int unsigned IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 sck_i,
  input  logic                 ss_n_i,
  input  logic                 mosi_i,
  output logic [31:0]          word_o,
  output logic [IDX_W-1:0]     word_index_o,
  output logic                 word_valid_o,
  input  logic                 word_ready_i,
  output logic                 frame_done_o,
  output logic                 frame_error_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] frame_count_o
);

  localparam int unsigned BCNT_W = $clog2(FRAME_BYTES + 2);
  localparam logic [BCNT_W-1:0] FULL_CNT = BCNT_W'(FRAME_BYTES);
  localparam logic [BCNT_W-1:0] SAT_CNT  = BCNT_W'(FRAME_BYTES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {RxWaitIdle, RxIdle, RxShift, RxCheck} rx_state_e;
  typedef enum logic {TxIdle, TxSend} tx_state_e;

  // Synchronisers plus one registered edge-detect stage. ss_n resets to 0 so a
  // genuine high level must be observed before the receiver arms.
  logic [1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic       sck_prev_q, ss_prev_q, mosi_prev_q;
  logic       sck_rise_q, ss_rise_q, ss_fall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
      mosi_prev_q <= 1'b0;
      sck_rise_q  <= 1'b0;
      ss_rise_q   <= 1'b0;
      ss_fall_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck_i};
      ss_sync_q   <= {ss_sync_q[0], ss_n_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      sck_prev_q  <= sck_sync_q[1];
      ss_prev_q   <= ss_sync_q[1];
      // mosi is delayed alongside the edge pulses so the captured bit lines up
      mosi_prev_q <= mosi_sync_q[1];
      sck_rise_q  <= sck_sync_q[1] & ~sck_prev_q;
      ss_rise_q   <= ss_sync_q[1] & ~ss_prev_q;
      ss_fall_q   <= ~ss_sync_q[1] & ss_prev_q;
    end
  end

  rx_state_e               rx_state_q, rx_state_d;
  tx_state_e               tx_state_q, tx_state_d;
  logic [6:0]              shift_q;
  logic [2:0]              bit_cnt_q;
  logic [BCNT_W-1:0]       byte_cnt_q;
  logic [8*FRAME_BYTES-1:0] frame_q, buf_q;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_WIDTH-1:0]    frame_cnt_q;

  logic good, check, last_accept, tx_free, load;

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RxWaitIdle: if (ss_prev_q) rx_state_d = RxIdle;
      RxIdle:     if (ss_fall_q) rx_state_d = RxShift;
      RxShift:    if (ss_rise_q) rx_state_d = RxCheck;
      RxCheck:    rx_state_d = RxIdle;
      default:    rx_state_d = RxWaitIdle;
    endcase
  end

  // Bytes shift in at the bottom, so byte 0 ends up in the top byte lane.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RxWaitIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      frame_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      if (rx_state_q == RxIdle && ss_fall_q) begin
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
      end else if (rx_state_q == RxShift && sck_rise_q && !ss_rise_q) begin
        shift_q   <= {shift_q[5:0], mosi_prev_q};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_cnt_q < FULL_CNT) begin
            frame_q <= {frame_q[8*FRAME_BYTES-9:0], shift_q, mosi_prev_q};
          end
          if (byte_cnt_q != SAT_CNT) byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
        end
      end
    end
  end

  assign good        = (byte_cnt_q == FULL_CNT) && (bit_cnt_q == 3'd0);
  assign check       = (rx_state_q == RxCheck);
  assign last_accept = (tx_state_q == TxSend) && word_ready_i && (idx_q == LAST_IDX);
  // A frame finishing in the same cycle frees the buffer for the new one.
  assign tx_free     = (tx_state_q == TxIdle) || last_accept;
  assign load        = check && good && tx_free;

  always_comb begin
    tx_state_d = tx_state_q;
    idx_d      = idx_q;
    if (load) begin
      tx_state_d = TxSend;
      idx_d      = '0;
    end else if (tx_state_q == TxSend && word_ready_i) begin
      if (idx_q == LAST_IDX) begin
        tx_state_d = TxIdle;
        idx_d      = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q  <= TxIdle;
      idx_q       <= '0;
      buf_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      idx_q      <= idx_d;
      if (load) begin
        buf_q       <= frame_q;
        frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign word_o        = buf_q[32*idx_q +: 32];
  assign word_index_o  = idx_q;
  assign word_valid_o  = (tx_state_q == TxSend);
  assign frame_done_o  = last_accept;
  assign frame_error_o = check && !good;
  assign overflow_o    = check && good && !tx_free;
  assign frame_count_o = frame_cnt_q;

endmodule

// File: tb/tb_darkroom_spi_frame_receiver.sv
// Directed bench for darkroom_spi_frame_receiver: SPI frames are bit-banged
// into the DUT, a monitor logs accepted words and pulses, and each scenario
// task compares the log against hand-computed expectations.
module tb_darkroom_spi_frame_receiver;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sck_i = 1'b0;
  logic        ss_n_i = 1'b1;
  logic        mosi_i = 1'b0;
  logic        word_ready_i = 1'b0;
  logic [31:0] word_o;
  logic [2:0]  word_index_o;
  logic        word_valid_o;
  logic        frame_done_o;
  logic        frame_error_o;
  logic        overflow_o;
  logic [15:0] frame_count_o;

  darkroom_spi_frame_receiver #(
    .FRAME_BYTES(32),
    .CNT_WIDTH  (16)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sck_i        (sck_i),
    .ss_n_i       (ss_n_i),
    .mosi_i       (mosi_i),
    .word_o       (word_o),
    .word_index_o (word_index_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .frame_done_o (frame_done_o),
    .frame_error_o(frame_error_o),
    .overflow_o   (overflow_o),
    .frame_count_o(frame_count_o)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // 0: ready low, 1: ready high, 2: toggle every cycle
  int ready_mode = 0;

  logic [31:0] got_word[$];
  int          got_idx[$];
  int          done_cnt = 0, err_cnt = 0, ovf_cnt = 0, valid_cnt = 0, hold_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word = '0;
  logic [2:0]  prev_idx = '0;

  initial begin : ready_drv
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       word_ready_i = 1'b0;
        1:       word_ready_i = 1'b1;
        default: word_ready_i = ~word_ready_i;
      endcase
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (frame_done_o)  done_cnt++;
      if (frame_error_o) err_cnt++;
      if (overflow_o)    ovf_cnt++;
      if (word_valid_o)  valid_cnt++;
      if (prev_stall && (!word_valid_o || word_o !== prev_word || word_index_o !== prev_idx))
        hold_viol++;
      if (word_valid_o && word_ready_i) begin
        got_word.push_back(word_o);
        got_idx.push_back(int'(word_index_o));
      end
      prev_stall = word_valid_o && !word_ready_i;
      prev_word  = word_o;
      prev_idx   = word_index_o;
    end
  end

  // Byte n of a frame is base+n; word k holds bytes 28-4k .. 31-4k.
  function automatic logic [31:0] exp_word(input int base, input int k);
    int n0;
    n0 = 28 - 4 * k;
    return {8'(base + n0), 8'(base + n0 + 1), 8'(base + n0 + 2), 8'(base + n0 + 3)};
  endfunction

  function automatic logic [31:0] got_at(input int i);
    if (i < got_word.size()) return got_word[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic int idx_at(input int i);
    if (i < got_idx.size()) return got_idx[i];
    return -1;
  endfunction

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bit(input logic b);
    mosi_i = b;
    clk_wait(4);
    sck_i = 1'b1;
    clk_wait(4);
    sck_i = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic spi_open();
    @(negedge clock);
    ss_n_i = 1'b0;
    clk_wait(6);
  endtask

  task automatic spi_bytes(input int base, input int n);
    for (int i = 0; i < n; i++) spi_byte(8'(base + i));
  endtask

  task automatic spi_close();
    clk_wait(4);
    ss_n_i = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    clk_wait(3);
    reset_n = 1'b1;
    clk_wait(10);
  endtask

  task automatic test_reset();
    clk_wait(3);
    vectors++;
    if ({word_valid_o, frame_done_o, frame_error_o, overflow_o} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000",
               {word_valid_o, frame_done_o, frame_error_o, overflow_o});
    end
    vectors++;
    if (word_o !== 32'h0 || word_index_o !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_word: got %h/%0d expected 00000000/0", word_o, word_index_o);
    end
    vectors++;
    if (frame_count_o !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d expected 0", frame_count_o);
    end
    reset_n = 1'b1;
    clk_wait(10);
    vectors++;
    if (word_valid_o !== 1'b0 || frame_count_o !== 16'd0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got valid %b count %0d expected 0/0",
               word_valid_o, frame_count_o);
    end
  endtask

  task automatic test_single_frame();
    int s, d0, e0, o0;
    ready_mode = 1;
    s = got_word.size(); d0 = done_cnt; e0 = err_cnt; o0 = ovf_cnt;
    spi_open();
    spi_bytes(0, 32);
    clk_wait(4);
    ss_n_i = 1'b1;
    clk_wait(4);
    vectors++;
    if (word_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: got valid %b expected 0", word_valid_o);
    end
    clk_wait(1);
    vectors++;
    if (word_valid_o !== 1'b1 || word_index_o !== 3'd0 || word_o !== 32'h1C1D1E1F) begin
      miscompares++;
      $display("FAIL latency_first: got %b/%0d/%h expected 1/0/1c1d1e1f",
               word_valid_o, word_index_o, word_o);
    end
    clk_wait(30);
    vectors++;
    if (got_word.size() - s !== 8) begin
      miscompares++;
      $display("FAIL single_count: got %0d words expected 8", got_word.size() - s);
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (got_at(s + k) !== exp_word(0, k) || idx_at(s + k) != k) begin
        miscompares++;
        $display("FAIL single_word%0d: got %h/%0d expected %h/%0d",
                 k, got_at(s + k), idx_at(s + k), exp_word(0, k), k);
      end
    end
    vectors++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || ovf_cnt - o0 != 0 || frame_count_o !== 16'd1)
    begin
      miscompares++;
      $display("FAIL single_pulses: got done %0d err %0d ovf %0d count %0d expected 1 0 0 1",
               done_cnt - d0, err_cnt - e0, ovf_cnt - o0, frame_count_o);
    end
  endtask

  task automatic test_bad_length();
    int e0, v0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      e0 = err_cnt; v0 = valid_cnt;
      spi_open();
      if (c == 0) spi_bytes(0, 31);
      else if (c == 1) spi_bytes(0, 33);
      else begin
        spi_bytes(0, 32);
        for (int b = 0; b < 3; b++) spi_bit(1'b1);
      end
      spi_close();
      clk_wait(20);
      vectors++;
      if (err_cnt - e0 != 1 || valid_cnt - v0 != 0) begin
        miscompares++;
        $display("FAIL bad_len_case%0d: got err %0d valid cycles %0d expected 1 0",
                 c, err_cnt - e0, valid_cnt - v0);
      end
    end
    vectors++;
    if (frame_count_o !== 16'd0) begin
      miscompares++;
      $display("FAIL bad_len_count: got %0d expected 0", frame_count_o);
    end
  endtask

  task automatic test_overflow();
    int s, o0;
    do_reset();
    ready_mode = 0;
    o0 = ovf_cnt;
    spi_open(); spi_bytes(0, 32); spi_close();
    clk_wait(20);
    spi_open(); spi_bytes(8'h40, 32); spi_close();
    clk_wait(20);
    vectors++;
    if (ovf_cnt - o0 != 1 || frame_count_o !== 16'd1) begin
      miscompares++;
      $display("FAIL overflow_pulse: got ovf %0d count %0d expected 1 1",
               ovf_cnt - o0, frame_count_o);
    end
    vectors++;
    if (word_valid_o !== 1'b1 || word_index_o !== 3'd0 || word_o !== exp_word(0, 0)) begin
      miscompares++;
      $display("FAIL overflow_hold: got %b/%0d/%h expected 1/0/%h",
               word_valid_o, word_index_o, word_o, exp_word(0, 0));
    end
    s = got_word.size();
    ready_mode = 1;
    clk_wait(20);
    vectors++;
    if (got_word.size() - s !== 8) begin
      miscompares++;
      $display("FAIL overflow_count: got %0d words expected 8", got_word.size() - s);
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (got_at(s + k) !== exp_word(0, k)) begin
        miscompares++;
        $display("FAIL overflow_word%0d: got %h expected %h", k, got_at(s + k), exp_word(0, k));
      end
    end
  endtask

  task automatic test_ready_toggle();
    int s, d0, h0;
    ready_mode = 2;
    s = got_word.size(); d0 = done_cnt; h0 = hold_viol;
    spi_open(); spi_bytes(8'h80, 32); spi_close();
    clk_wait(40);
    vectors++;
    if (got_word.size() - s !== 8 || hold_viol - h0 != 0 || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL toggle_summary: got words %0d hold errs %0d done %0d expected 8 0 1",
               got_word.size() - s, hold_viol - h0, done_cnt - d0);
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (got_at(s + k) !== exp_word(8'h80, k) || idx_at(s + k) != k) begin
        miscompares++;
        $display("FAIL toggle_word%0d: got %h/%0d expected %h/%0d",
                 k, got_at(s + k), idx_at(s + k), exp_word(8'h80, k), k);
      end
    end
    vectors++;
    if (frame_count_o !== 16'd2) begin
      miscompares++;
      $display("FAIL toggle_count: got %0d expected 2", frame_count_o);
    end
    ready_mode = 1;
  endtask

  task automatic test_reset_mid_frame();
    int s, v0, e0, o0, d0;
    ready_mode = 1;
    v0 = valid_cnt; e0 = err_cnt; o0 = ovf_cnt; d0 = done_cnt;
    spi_open();
    spi_bytes(0, 10);
    for (int b = 0; b < 4; b++) spi_bit(b[0]);
    reset_n = 1'b0;
    clk_wait(3);
    reset_n = 1'b1;
    spi_bytes(8'h10, 22);
    spi_close();
    clk_wait(30);
    vectors++;
    if (valid_cnt - v0 != 0 || err_cnt - e0 != 0 || ovf_cnt - o0 != 0 || done_cnt - d0 != 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: got valid %0d err %0d ovf %0d done %0d expected 0 0 0 0",
               valid_cnt - v0, err_cnt - e0, ovf_cnt - o0, done_cnt - d0);
    end
    vectors++;
    if (frame_count_o !== 16'd0) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d expected 0", frame_count_o);
    end
    s = got_word.size();
    spi_open(); spi_bytes(8'h20, 32); spi_close();
    clk_wait(30);
    vectors++;
    if (got_word.size() - s !== 8 || got_at(s) !== exp_word(8'h20, 0) ||
        got_at(s + 7) !== exp_word(8'h20, 7) || frame_count_o !== 16'd1) begin
      miscompares++;
      $display("FAIL midreset_next: got n %0d w0 %h w7 %h count %0d expected 8 %h %h 1",
               got_word.size() - s, got_at(s), got_at(s + 7), frame_count_o,
               exp_word(8'h20, 0), exp_word(8'h20, 7));
    end
  endtask

  task automatic test_back_to_back();
    int s, o0, d0;
    ready_mode = 0;
    spi_open(); spi_bytes(8'h60, 32); spi_close();
    clk_wait(20);
    s = got_word.size(); d0 = done_cnt;
    ready_mode = 1;
    clk_wait(7);
    ready_mode = 0;
    clk_wait(4);
    vectors++;
    if (got_word.size() - s !== 7 || word_valid_o !== 1'b1 || word_index_o !== 3'd7) begin
      miscompares++;
      $display("FAIL b2b_park: got words %0d valid %b idx %0d expected 7 1 7",
               got_word.size() - s, word_valid_o, word_index_o);
    end
    o0 = ovf_cnt;
    spi_open();
    spi_bytes(8'hC0, 32);
    clk_wait(4);
    ss_n_i = 1'b1;
    clk_wait(3);
    ready_mode = 1;
    clk_wait(2);
    vectors++;
    if (word_valid_o !== 1'b1 || word_index_o !== 3'd0 || word_o !== exp_word(8'hC0, 0)) begin
      miscompares++;
      $display("FAIL b2b_switch: got %b/%0d/%h expected 1/0/%h",
               word_valid_o, word_index_o, word_o, exp_word(8'hC0, 0));
    end
    clk_wait(20);
    vectors++;
    if (ovf_cnt - o0 != 0 || done_cnt - d0 != 2 || got_word.size() - s !== 16 ||
        frame_count_o !== 16'd3) begin
      miscompares++;
      $display("FAIL b2b_summary: got ovf %0d done %0d words %0d count %0d expected 0 2 16 3",
               ovf_cnt - o0, done_cnt - d0, got_word.size() - s, frame_count_o);
    end
    vectors++;
    if (got_at(s + 7) !== exp_word(8'h60, 7) || idx_at(s + 7) != 7) begin
      miscompares++;
      $display("FAIL b2b_last_old: got %h/%0d expected %h/7",
               got_at(s + 7), idx_at(s + 7), exp_word(8'h60, 7));
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (got_at(s + 8 + k) !== exp_word(8'hC0, k) || idx_at(s + 8 + k) != k) begin
        miscompares++;
        $display("FAIL b2b_word%0d: got %h/%0d expected %h/%0d",
                 k, got_at(s + 8 + k), idx_at(s + 8 + k), exp_word(8'hC0, k), k);
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_single_frame();
    test_bad_length();
    test_overflow();
    test_ready_toggle();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
